// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed, big-endian program image from a valid/ready byte source into instruction memory.
// Optional trailing XOR checksum byte is enabled with the CHECKSUM_EN macro.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
`ifdef CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic [15:0] widx;
    logic [1:0]  bidx;
    logic [23:0] word;
`ifdef CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic [15:0] hdr_n;
    logic        xfer;

    // The high header byte is parked in count[15:8] until the low byte arrives.
    assign hdr_n = {count[15:8], rx_data};
    assign xfer  = rx_valid && rx_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= HDR_HI;
            count     <= '0;
            widx      <= '0;
            bidx      <= '0;
            word      <= '0;
`ifdef CHECKSUM_EN
            csum      <= '0;
`endif
            rx_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            cpu_reset <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            // Delayed copy of done so the final write lands before the first fetch.
            cpu_reset <= done;
            if (xfer) begin
                case (state)
                    HDR_HI: begin
                        count[15:8] <= rx_data;
                        state       <= HDR_LO;
                    end
                    HDR_LO: begin
                        count <= hdr_n;
                        if ({16'd0, hdr_n} > MAX_WORDS) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            rx_ready <= 1'b0;
                        end else if (hdr_n == 16'd0) begin
`ifdef CHECKSUM_EN
                            state    <= CSUM;
`else
                            state    <= DONE;
                            done     <= 1'b1;
                            rx_ready <= 1'b0;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
`ifdef CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        word <= {word[15:0], rx_data};
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= BASE_ADDR + {14'd0, widx, 2'b00};
                            mem_wdata <= {word, rx_data};
                            widx      <= widx + 16'd1;
                            if (widx == count - 16'd1) begin
`ifdef CHECKSUM_EN
                                state    <= CSUM;
`else
                                state    <= DONE;
                                done     <= 1'b1;
                                rx_ready <= 1'b0;
`endif
                            end
                        end
                    end
`ifdef CHECKSUM_EN
                    CSUM: begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: random images checked against an image-level model of the expected memory writes and outcome.
module tb_imem_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 256;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the next expected (addr, data) pair.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_addr.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                check("mem_addr", mem_addr, exp_addr.pop_front());
                check("mem_wdata", mem_wdata, exp_data.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rx_valid = 1'b0;
        reset    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = $urandom();
    endtask

    function automatic bq_t make_image(input int n);
        bq_t q;
        q.push_back(n[15:8]);
        q.push_back(n[7:0]);
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom()));
        return q;
    endfunction

    // Model: header N, N big-endian words at BASE+4i, optional XOR trailer.
    task automatic run_image(input bq_t img, input int max_gap, input bit bad_csum);
        int          n;
        bit          ok;
        bit          too_big;
        logic [7:0]  x;
        logic [31:0] w;
        logic        saw_cpu;
        bq_t         tx;
        do_reset();
        n       = {img[0], img[1]};
        too_big = (n > int'(MAXW));
        ok      = !too_big;
        x       = '0;
        tx.push_back(img[0]);
        tx.push_back(img[1]);
        if (!too_big) begin
            for (int i = 0; i < n; i++) begin
                w = '0;
                for (int k = 0; k < 4; k++) begin
                    w = (w << 8) | 32'(img[2 + 4 * i + k]);
                    x = x ^ img[2 + 4 * i + k];
                    tx.push_back(img[2 + 4 * i + k]);
                end
                exp_addr.push_back(BASE + 32'(i) * 32'd4);
                exp_data.push_back(w);
            end
`ifdef CHECKSUM_EN
            tx.push_back(bad_csum ? (x ^ 8'h01) : x);
            ok = !bad_csum;
`endif
        end
        foreach (tx[i]) send_byte(tx[i], max_gap);
        check("done", {31'd0, done}, {31'd0, ok});
        check("err", {31'd0, err}, {31'd0, !ok});
        check("rx_ready_end", {31'd0, rx_ready}, 32'd0);
        check("cpu_reset_lag", {31'd0, cpu_reset}, 32'd0);
`ifndef CHECKSUM_EN
        check("last_we_with_done", {31'd0, mem_we}, {31'd0, (n != 0) && ok});
`endif
        @(posedge clk); #1;
        check("cpu_reset_rise", {31'd0, cpu_reset}, {31'd0, ok});
        if (!ok) begin
            saw_cpu = 1'b0;
            repeat (100) begin
                @(posedge clk); #1;
                saw_cpu = saw_cpu | cpu_reset;
            end
            check("cpu_reset_held_err", {31'd0, saw_cpu}, 32'd0);
        end
        @(posedge clk); #1;
        check("writes_outstanding", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        bq_t img;
        reset = 1'b0;

        // Fixed image from the datasheet example, back to back then with gaps.
        img = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
        run_image(img, 0, 1'b0);
        run_image(img, 5, 1'b0);
`ifdef CHECKSUM_EN
        run_image(img, 0, 1'b1);
        run_image(img, 3, 1'b1);
`endif

        // Empty image and capacity boundaries.
        run_image(make_image(0), 0, 1'b0);
        run_image(make_image(int'(MAXW)), 0, 1'b0);
        run_image(make_image(int'(MAXW) + 1), 0, 1'b0);
        run_image(make_image(int'($urandom_range(16'hFFFF, MAXW + 2))), 2, 1'b0);

        // Random images with random gaps.
        for (int t = 0; t < 12; t++)
            run_image(make_image(int'($urandom_range(9, 1))), int'($urandom_range(5, 0)), 1'b0);

        // Reset mid-word: word 0 completes, the partial word 1 is dropped.
        do_reset();
        img = make_image(2);
        exp_addr.push_back(BASE);
        exp_data.push_back({img[2], img[3], img[4], img[5]});
        for (int i = 0; i < 7; i++) send_byte(img[i], 1);
        @(posedge clk); #1;
        check("midword_writes", 32'(exp_addr.size()), 32'd0);
        check("midword_done", {31'd0, done}, 32'd0);
        run_image(make_image(1), 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got still running expected finished");
        $fatal(1, "timeout");
    end

endmodule
